// File: rtl/fifo_serial_tx_if.sv
// FIFO-side pop handshake plus the serial line and status outputs of the drain stage.
interface fifo_serial_tx_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic             fifo_empty;
  logic             fifo_rd;
  logic [WIDTH-1:0] fifo_data;
  logic             tx;
  logic             busy;
  logic             frame_done;

  modport master (
    output enable, fifo_empty, fifo_data,
    input  fifo_rd, tx, busy, frame_done
  );

  modport slave (
    input  enable, fifo_empty, fifo_data,
    output fifo_rd, tx, busy, frame_done
  );
endinterface

// File: rtl/fifo_serial_tx.sv
// Pops one FIFO word and shifts it out as a UART frame (start, LSB-first data, optional parity, stop).
// Three idle-high cycles (IDLE, READ, LATCH) separate frames; enable/fifo_empty are only sampled in IDLE.
module fifo_serial_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input logic          clk,
  input logic          reset,
  fifo_serial_tx_if.slave bus
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(WIDTH + 1);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(WIDTH - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic          ODD_BIT   = (PARITY_ODD != 0);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] READ   = 3'd1;
  localparam logic [2:0] LATCH  = 3'd2;
  localparam logic [2:0] START  = 3'd3;
  localparam logic [2:0] DATA   = 3'd4;
  localparam logic [2:0] PARITY = 3'd5;
  localparam logic [2:0] STOP   = 3'd6;

  logic [2:0]       state;
  logic [BW-1:0]    baud;
  logic [IW-1:0]    bit_idx;
  logic [WIDTH-1:0] shreg;
  logic             par_acc;
  logic             tx_q;
  logic             rd_q;
  logic             busy_q;
  logic             done_q;

  logic baud_last;
  assign baud_last = (baud == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_acc <= 1'b0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      rd_q   <= 1'b0;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          baud    <= '0;
          bit_idx <= '0;
          if (bus.enable && !bus.fifo_empty) begin
            state  <= READ;
            rd_q   <= 1'b1;
            busy_q <= 1'b1;
          end
        end
        READ: begin
          state <= LATCH;
        end
        LATCH: begin
          // FIFO read data is valid in the cycle following the pop
          shreg   <= bus.fifo_data;
          par_acc <= 1'b0;
          baud    <= '0;
          tx_q    <= 1'b0;
          state   <= START;
        end
        START: begin
          if (baud_last) begin
            baud    <= '0;
            bit_idx <= '0;
            tx_q    <= shreg[0];
            par_acc <= par_acc ^ shreg[0];
            shreg   <= {1'b0, shreg[WIDTH-1:1]};
            state   <= DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud <= '0;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                tx_q  <= par_acc ^ ODD_BIT;
                state <= PARITY;
              end else begin
                tx_q  <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + IW'(1);
              tx_q    <= shreg[0];
              par_acc <= par_acc ^ shreg[0];
              shreg   <= {1'b0, shreg[WIDTH-1:1]};
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        PARITY: begin
          if (baud_last) begin
            baud  <= '0;
            tx_q  <= 1'b1;
            state <= STOP;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (baud_last) begin
            baud <= '0;
            // bit_idx is reused to count stop bits
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              state   <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          baud    <= '0;
          bit_idx <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx         = tx_q;
  assign bus.fifo_rd    = rd_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench: three instances (no parity, even, odd) at CLKS_PER_BIT=4, each fed by a small FIFO model.
module tb_fifo_serial_tx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic       en [3];
  logic       hold_empty [3];
  logic       empty_w [3];
  logic       rd_w [3];
  logic       tx_w [3];
  logic       busy_w [3];
  logic       fd_w [3];
  logic [7:0] fdat [3] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] qmem [3][16];
  int         qhead [3] = '{0, 0, 0};
  int         qtail [3];
  int         rd_cnt [3] = '{0, 0, 0};
  int         fd_cnt [3] = '{0, 0, 0};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fifo_serial_tx_if #(.WIDTH(8)) bus ();
    assign bus.enable     = en[g];
    assign bus.fifo_empty = empty_w[g];
    assign bus.fifo_data  = fdat[g];
    assign empty_w[g]     = hold_empty[g] | (qhead[g] >= qtail[g]);
    assign rd_w[g]        = bus.fifo_rd;
    assign tx_w[g]        = bus.tx;
    assign busy_w[g]      = bus.busy;
    assign fd_w[g]        = bus.frame_done;

    fifo_serial_tx #(
      .WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1),
      .PARITY_EN(g > 0 ? 1 : 0), .PARITY_ODD(g == 2 ? 1 : 0)
    ) dut (
      .clk(clk), .reset(reset), .bus(bus.slave)
    );
  end

  // FIFO model: data appears the cycle after the pop
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rd_w[g] === 1'b1) begin
        fdat[g]  <= qmem[g][qhead[g] % 16];
        qhead[g] <= qhead[g] + 1;
        rd_cnt[g] <= rd_cnt[g] + 1;
      end
      if (fd_w[g] === 1'b1) fd_cnt[g] <= fd_cnt[g] + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int g, input logic [7:0] w);
    qmem[g][qtail[g] % 16] = w;
    qtail[g]++;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Waits (bounded) for the start bit, then checks every cycle of every bit; returns at the first IDLE cycle.
  task automatic run_frame(input int g, input string name, input string bits, input int drop_at);
    int n;
    logic exp_b, act_b, bz;
    n = 0;
    while (tx_w[g] !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, " start_seen"}, 32'(n < 200), 32'd1);
    if (n >= 200) return;
    bz = 1'b1;
    for (int b = 0; b < bits.len(); b++) begin
      exp_b = (bits[b] == "1");
      act_b = exp_b;
      for (int c = 0; c < 4; c++) begin
        if (b * 4 + c == drop_at) en[g] = 1'b0;
        if (tx_w[g] !== exp_b) act_b = tx_w[g];
        if (busy_w[g] !== 1'b1) bz = 1'b0;
        @(negedge clk);
      end
      check($sformatf("%s bit%0d", name, b), 32'(act_b), 32'(exp_b));
    end
    check({name, " busy_in_frame"}, 32'(bz), 32'd1);
    check({name, " frame_done"}, 32'(fd_w[g]), 32'd1);
    check({name, " busy_after"}, 32'(busy_w[g]), 32'd0);
  endtask

  typedef struct {
    int         dut;
    logic [7:0] word;
    string      bits;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rd0, fd0, n;
    logic ok_tx, ok_busy;

    vecs[0] = '{dut: 0, word: 8'hA5, bits: "0101001011"};
    vecs[1] = '{dut: 1, word: 8'hA5, bits: "01010010101"};
    vecs[2] = '{dut: 2, word: 8'hA5, bits: "01010010111"};
    vecs[3] = '{dut: 0, word: 8'h3C, bits: "0001111001"};

    for (int g = 0; g < 3; g++) begin
      qtail[g] = 0;
      en[g] = 1'b0;
      hold_empty[g] = 1'b0;
    end

    // Reset with random inputs
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int g = 0; g < 3; g++) begin
        en[g] = 1'($urandom_range(0, 1));
        hold_empty[g] = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      for (int g = 0; g < 3; g++)
        check($sformatf("reset%0d dut%0d outs", i, g),
              {28'd0, tx_w[g], rd_w[g], busy_w[g], fd_w[g]}, 32'h8);
    end
    for (int g = 0; g < 3; g++) begin
      en[g] = 1'b0;
      hold_empty[g] = 1'b0;
    end
    reset = 1'b0;
    wait_cycles(2);

    // Single frames: plain, even parity, odd parity, second plain word
    for (int v = 0; v < 4; v++) begin
      rd0 = rd_cnt[vecs[v].dut];
      fd0 = fd_cnt[vecs[v].dut];
      push(vecs[v].dut, vecs[v].word);
      en[vecs[v].dut] = 1'b1;
      run_frame(vecs[v].dut, $sformatf("vec%0d", v), vecs[v].bits, -1);
      en[vecs[v].dut] = 1'b0;
      wait_cycles(3);
      check($sformatf("vec%0d rd_pulses", v), 32'(rd_cnt[vecs[v].dut] - rd0), 32'd1);
      check($sformatf("vec%0d done_pulses", v), 32'(fd_cnt[vecs[v].dut] - fd0), 32'd1);
    end

    // Back-to-back frames with exactly 3 idle-high cycles between them
    rd0 = rd_cnt[0];
    push(0, 8'h01);
    push(0, 8'hFF);
    en[0] = 1'b1;
    run_frame(0, "b2b1", "0100000001", -1);
    n = 0;
    while (tx_w[0] === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b gap_cycles", 32'(n), 32'd3);
    run_frame(0, "b2b2", "0111111111", -1);
    wait_cycles(10);
    check("b2b rd_pulses", 32'(rd_cnt[0] - rd0), 32'd2);
    en[0] = 1'b0;

    // Empty FIFO with enable high, then data present with enable low
    rd0 = rd_cnt[0];
    en[0] = 1'b1;
    ok_tx = 1'b1;
    ok_busy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1) ok_tx = 1'b0;
      if (busy_w[0] !== 1'b0) ok_busy = 1'b0;
    end
    en[0] = 1'b0;
    push(0, 8'h3C);
    push(0, 8'h55);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1) ok_tx = 1'b0;
      if (busy_w[0] !== 1'b0) ok_busy = 1'b0;
    end
    check("stall rd_pulses", 32'(rd_cnt[0] - rd0), 32'd0);
    check("stall tx_high", 32'(ok_tx), 32'd1);
    check("stall busy_low", 32'(ok_busy), 32'd1);

    // Enable dropped mid-DATA: frame completes, nothing further popped
    en[0] = 1'b1;
    run_frame(0, "drop", "0001111001", 14);
    wait_cycles(100);
    check("drop rd_pulses", 32'(rd_cnt[0] - rd0), 32'd1);
    check("drop parked_busy", 32'(busy_w[0]), 32'd0);

    // Reset during the 3rd data bit of 0x55, then a clean fresh frame
    rd0 = rd_cnt[0];
    fd0 = fd_cnt[0];
    en[0] = 1'b1;
    n = 0;
    while (tx_w[0] !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("abort start_seen", 32'(n < 50), 32'd1);
    wait_cycles(13);
    check("abort mid_bit2", {30'd0, tx_w[0], busy_w[0]}, 32'h3);
    reset = 1'b1;
    @(negedge clk);
    check("abort reset_outs", {28'd0, tx_w[0], rd_w[0], busy_w[0], fd_w[0]}, 32'h8);
    push(0, 8'h3C);
    @(negedge clk);
    reset = 1'b0;
    check("abort no_done", 32'(fd_cnt[0] - fd0), 32'd0);
    run_frame(0, "fresh", "0001111001", -1);
    en[0] = 1'b0;
    wait_cycles(3);
    check("fresh rd_pulses", 32'(rd_cnt[0] - rd0), 32'd2);
    check("fresh done_pulses", 32'(fd_cnt[0] - fd0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
